// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for the multi-cycle ALU.
// Latency: none, this is wiring only.
// Backpressure: in_ready/out_ready carry the stall in each direction.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  // Producer/consumer side: issues operations and accepts results.
  modport master (
    output in_valid, a, b, alu_control, out_ready,
    input  in_ready, out_valid, result, zero
  );

  // ALU side.
  modport slave (
    input  in_valid, a, b, alu_control, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: logic/arith/shift ops in one cycle, iterative MUL/DIVU/REMU.
// Latency: result valid 1 cycle after accept, or WIDTH+1 cycles for MUL/DIVU/REMU.
// Backpressure: result is held in DONE until out_ready; no accept while BUSY.
module alu_mc #(
  parameter int WIDTH     = 32,
  parameter bit EN_MULDIV = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_mc_if.slave   bus,
  output logic      busy
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [SW-1:0]    cnt;
  logic [1:0]       op_r;       // 00 MUL, 01 DIVU, 10 REMU
  logic [WIDTH-1:0] x_r;        // MUL: shifted multiplicand; DIV: dividend/quotient
  logic [WIDTH-1:0] y_r;        // MUL: shifted multiplier;   DIV: divisor
  logic [WIDTH-1:0] acc_r;      // MUL: partial product;      DIV: partial remainder
  logic             out_valid_r;
  logic             zero_r;
  logic [WIDTH-1:0] result_r;
  logic             busy_r;
  logic             rdy;
  logic             is_long;
  logic [WIDTH-1:0] fast_res;

  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] x_nx;
  logic [WIDTH-1:0] y_nx;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] long_res;

  assign rdy           = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.zero      = zero_r;
  assign busy          = busy_r;

  assign is_long = EN_MULDIV && ((bus.alu_control == 4'b1100) ||
                                 (bus.alu_control == 4'b1101) ||
                                 (bus.alu_control == 4'b1110));

  // Single-cycle result; MUL/DIVU/REMU codes fall to 0 here (used when EN_MULDIV=0).
  always_comb begin
    fast_res = '0;
    case (bus.alu_control)
      4'b0000: fast_res = bus.a & bus.b;
      4'b0001: fast_res = bus.a | bus.b;
      4'b0010: fast_res = bus.a + bus.b;
      4'b0011: fast_res = bus.a ^ bus.b;
      4'b0110: fast_res = bus.a - bus.b;
      4'b0111: fast_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'b1011: fast_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      4'b1000: fast_res = bus.a << bus.b[SW-1:0];
      4'b1001: fast_res = bus.a >> bus.b[SW-1:0];
      4'b1010: fast_res = $unsigned($signed(bus.a) >>> bus.b[SW-1:0]);
      default: fast_res = '0;
    endcase
  end

  // One iteration of shift-add multiply / restoring divide. A zero divisor
  // naturally yields an all-ones quotient and leaves the dividend as remainder.
  always_comb begin
    mul_acc = acc_r + (y_r[0] ? x_r : '0);
    div_sh  = {acc_r, x_r[WIDTH-1]};
    div_sub = div_sh - {1'b0, y_r};
    div_ge  = ~div_sub[WIDTH];
    div_rem = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_quo = {x_r[WIDTH-2:0], div_ge};
    if (op_r == 2'b00) begin
      acc_nx = mul_acc;
      x_nx   = {x_r[WIDTH-2:0], 1'b0};
      y_nx   = {1'b0, y_r[WIDTH-1:1]};
    end else begin
      acc_nx = div_rem;
      x_nx   = div_quo;
      y_nx   = y_r;
    end
    case (op_r)
      2'b00:   long_res = mul_acc;
      2'b01:   long_res = div_quo;
      default: long_res = div_rem;
    endcase
  end

  // Control FSM with registered result/zero/out_valid/busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_r        <= '0;
      x_r         <= '0;
      y_r         <= '0;
      acc_r       <= '0;
      out_valid_r <= 1'b0;
      zero_r      <= 1'b0;
      result_r    <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          x_r   <= x_nx;
          y_r   <= y_nx;
          acc_r <= acc_nx;
          cnt   <= cnt + SW'(1);
          if (cnt == LAST) begin
            state       <= DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            result_r    <= long_res;
            zero_r      <= (long_res == '0);
          end
        end
        default: begin
          // IDLE, or DONE with the result being taken this edge.
          if (rdy) begin
            if (bus.in_valid && is_long) begin
              state       <= BUSY;
              busy_r      <= 1'b1;
              out_valid_r <= 1'b0;
              cnt         <= '0;
              op_r        <= bus.alu_control[1:0];
              x_r         <= bus.a;
              y_r         <= bus.b;
              acc_r       <= '0;
            end else if (bus.in_valid) begin
              state       <= DONE;
              out_valid_r <= 1'b1;
              result_r    <= fast_res;
              zero_r      <= (fast_res == '0);
            end else begin
              state       <= IDLE;
              out_valid_r <= 1'b0;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, hand-written
// handshake/reset sequences, and random ops against a reference model.
module tb_alu_mc;
  logic clk;
  logic rst_n;
  logic busy;
  logic busy2;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mc_if #(.WIDTH(32)) bus ();
  alu_mc_if #(.WIDTH(32)) bus2 ();

  alu_mc #(.WIDTH(32), .EN_MULDIV(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy)
  );

  alu_mc #(.WIDTH(32), .EN_MULDIV(1'b0)) dut_nomd (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model written directly from the operation definitions.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa;
    int                 sh;
    sh = int'(b[4:0]);
    sa = a;
    case (op)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a + b;
      4'h3: return a ^ b;
      4'h6: return a - b;
      4'h7: return (sa < $signed(b)) ? 32'd1 : 32'd0;
      4'hB: return (a < b) ? 32'd1 : 32'd0;
      4'h8: return a << sh;
      4'h9: return a >> sh;
      4'hA: return $unsigned(sa >>> sh);
      4'hC: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      4'hD: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'hE: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Issue one op and follow it to its handshake. Entered and left at posedge+1.
  task automatic do_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp, input int exp_lat, input int stall,
                       input string nm);
    int          lat;
    int          nbusy;
    bit          got;
    bus.a           = av;
    bus.b           = bv;
    bus.alu_control = op;
    bus.in_valid    = 1'b1;
    bus.out_ready   = (stall == 0);
    chk({nm, " in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.a           = $urandom;
    bus.b           = $urandom;
    bus.alu_control = 4'($urandom_range(0, 15));
    lat   = 0;
    nbusy = 0;
    got   = 1'b0;
    while (!got && lat < 200) begin
      lat++;
      if (bus.out_valid) got = 1'b1;
      else begin
        nbusy += int'(busy);
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      chk({nm, " timeout"}, 32'(lat), 32'(exp_lat));
      bus.out_ready = 1'b1;
      return;
    end
    chk({nm, " result"}, bus.result, exp);
    chk({nm, " zero"}, 32'(bus.zero), 32'(exp == 0));
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " busy cycles"}, 32'(nbusy), 32'(exp_lat - 1));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk({nm, " held result"}, bus.result, exp);
      chk({nm, " held valid"}, 32'(bus.out_valid), 32'd1);
      chk({nm, " in_ready while held"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, " released"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int          nbusy;
    int          bad;
    int          n;
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vt[0]  = '{4'h2, 32'd5,          32'd7,          32'd12,         1};
    vt[1]  = '{4'h6, 32'd3,          32'd3,          32'd0,          1};
    vt[2]  = '{4'hA, 32'h8000_0000,  32'h24,         32'hF800_0000,  1};
    vt[3]  = '{4'h8, 32'd1,          32'd31,         32'h8000_0000,  1};
    vt[4]  = '{4'hC, 32'h0001_0001,  32'h0001_0001,  32'h0002_0001,  33};
    vt[5]  = '{4'hD, 32'd100,        32'd7,          32'd14,         33};
    vt[6]  = '{4'hE, 32'd100,        32'd7,          32'd2,          33};
    vt[7]  = '{4'hD, 32'd9,          32'd0,          32'hFFFF_FFFF,  33};
    vt[8]  = '{4'hE, 32'd9,          32'd0,          32'd9,          33};
    vt[9]  = '{4'h0, 32'hF0F0_FFFF,  32'h0FF0_F00F,  32'h00F0_F00F,  1};
    vt[10] = '{4'h1, 32'h0F00_0000,  32'h0000_00F0,  32'h0F00_00F0,  1};
    vt[11] = '{4'h3, 32'hA5A5_A5A5,  32'hFFFF_0000,  32'h5A5A_A5A5,  1};
    vt[12] = '{4'h9, 32'h8000_0000,  32'd31,         32'd1,          1};
    vt[13] = '{4'h7, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          1};
    vt[14] = '{4'h4, 32'd5,          32'd7,          32'd0,          1};
    vt[15] = '{4'hF, 32'd5,          32'd7,          32'd0,          1};
    vt[16] = '{4'hD, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vt[17] = '{4'hC, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          33};

    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.a            = '0;
    bus.b            = '0;
    bus.alu_control  = '0;
    bus2.in_valid    = 1'b0;
    bus2.out_ready   = 1'b0;
    bus2.a           = '0;
    bus2.b           = '0;
    bus2.alu_control = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset result", bus.result, 32'd0);
    chk("reset zero", 32'(bus.zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vectors.
    for (int i = 0; i < 18; i++)
      do_op(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, 0, $sformatf("vec%0d", i));

    // Back-to-back single-cycle ops: SLT then SLTU.
    bus.out_ready   = 1'b1;
    bus.alu_control = 4'h7;
    bus.a           = 32'hFFFF_FFFF;
    bus.b           = 32'd1;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    chk("b2b slt valid", 32'(bus.out_valid), 32'd1);
    chk("b2b slt result", bus.result, 32'd1);
    chk("b2b in_ready", 32'(bus.in_ready), 32'd1);
    bus.alu_control = 4'hB;
    @(posedge clk); #1;
    chk("b2b sltu valid", 32'(bus.out_valid), 32'd1);
    chk("b2b sltu result", bus.result, 32'd0);
    chk("b2b sltu zero", 32'(bus.zero), 32'd1);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b drained", 32'(bus.out_valid), 32'd0);

    // MUL with a held follow-on request and 5 cycles of consumer stall.
    bus.out_ready   = 1'b0;
    bus.alu_control = 4'hC;
    bus.a           = 32'h0001_0001;
    bus.b           = 32'h0001_0001;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.alu_control = 4'h2;
    bus.a           = 32'd20;
    bus.b           = 32'd22;
    n     = 0;
    nbusy = 0;
    bad   = 0;
    while (!bus.out_valid && n < 100) begin
      if (bus.in_ready) bad++;
      nbusy += int'(busy);
      @(posedge clk); #1;
      n++;
    end
    chk("mul stall busy cycles", 32'(nbusy), 32'd32);
    chk("mul in_ready while busy", 32'(bad), 32'd0);
    chk("mul stall valid", 32'(bus.out_valid), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("mul stall result", bus.result, 32'h0002_0001);
      chk("mul stall in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("re-accept valid", 32'(bus.out_valid), 32'd1);
    chk("re-accept add result", bus.result, 32'd42);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("re-accept drained", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a DIVU.
    bus.alu_control = 4'hD;
    bus.a           = 32'd100;
    bus.b           = 32'd7;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("divu mid busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset result", bus.result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("after reset in_ready", 32'(bus.in_ready), 32'd1);
    do_op(4'h2, 32'd1, 32'd1, 32'd2, 1, 0, "add after reset");

    // EN_MULDIV=0 instance: MUL/DIVU/REMU finish in one cycle with 0.
    bus2.out_ready = 1'b1;
    bus2.a         = 32'd9;
    bus2.b         = 32'd3;
    bus2.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus2.alu_control = 4'hC + 4'(k);
      @(posedge clk); #1;
      chk($sformatf("nomd op%0d valid", k), 32'(bus2.out_valid), 32'd1);
      chk($sformatf("nomd op%0d result", k), bus2.result, 32'd0);
      chk($sformatf("nomd op%0d zero", k), 32'(bus2.zero), 32'd1);
      chk($sformatf("nomd op%0d busy", k), 32'(busy2), 32'd0);
    end
    bus2.in_valid = 1'b0;

    // Random ops against the reference model, with random consumer stalls.
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      do_op(rop, ra, rb, ref_alu(rop, ra, rb),
            (rop == 4'hC || rop == 4'hD || rop == 4'hE) ? 33 : 1,
            $urandom_range(0, 2), $sformatf("rand%0d op%h", i, rop));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
